mac_acc8: RTL
=============

Name: mac_acc8

Overview:
- Downstream stage of the combinational 4x4 unsigned array multiplier.
- Consumes a stream of 8-bit products over a valid/ready handshake.
- Sums each group of N_TERMS consecutive products into a dot-product result, then holds that result on a valid/ready output until taken.
- Gives the multiplier datapath a registered, flow-controlled output for the next stage.

Parameters:
- N_TERMS, 4: products per result; legal range 1..256.
- ACC_W, 10: accumulator/result width; default is 8 + clog2(N_TERMS), so the default configuration cannot overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous discard of the partial sum; has priority over in_valid.
- in_valid  input  1  in_p is valid.
- in_ready  output  1  block accepts in_p this cycle.
- in_p  input  8  unsigned product a*b.
- out_valid  output  1  out_sum/out_ovf are valid.
- out_ready  input  1  downstream takes the result.
- out_sum  output  ACC_W  sum of N_TERMS products, modulo 2^ACC_W.
- out_ovf  output  1  a carry out of ACC_W occurred while forming this result.
- busy  output  1  partial sum in progress (cnt != 0).

Behaviour:
- Reset (async, rst=1):
  - state=ACC, acc=0, cnt=0, ovf_acc=0.
  - out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - in_ready goes to 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards any partial sum and any held result.
- States: ACC, HOLD.
- in_ready = (state==ACC) and not rst.
- Accept = in_valid & in_ready & ~clr.
- ACC, accept, cnt < N_TERMS-1: acc <= acc + in_p, truncated to ACC_W; ovf_acc |= carry; cnt++.
- ACC, accept, cnt == N_TERMS-1:
  - out_sum <= acc + in_p (truncated); out_ovf <= ovf_acc | carry.
  - out_valid <= 1; acc, cnt, ovf_acc <= 0; state <= HOLD.
  - Latency: out_valid rises on the clock edge after the final accept.
- HOLD:
  - in_ready=0; out_sum and out_ovf held stable.
  - out_ready=1: out_valid <= 0, state <= ACC. One-cycle bubble: next accept is possible no earlier than the cycle after the handshake.
- in_valid=0 in ACC: no change. Gaps between terms are allowed indefinitely.
- clr=1:
  - In ACC: acc, cnt, ovf_acc <= 0; a product presented the same cycle is not accepted, and in_ready stays 1.
  - In HOLD: no effect on the held result.
- N_TERMS=1: every accept goes straight to HOLD.
- Arithmetic: unsigned only. The adder is ACC_W+1 bits wide; bit ACC_W is the carry.
- out_valid must not drop without an out_ready handshake.
- out_sum must not change while out_valid=1.

Decomposition:
- Shared package mac_pkg holds:
  - state enum {ACC, HOLD};
  - function clog2;
  - constant PROD_W = 8.
- One natural sub-module: acc_add, an ACC_W-bit adder with zero-extended 8-bit input and carry out.
- The FSM, counter and output register stay in mac_acc8.

Test Plan:
- Basic: defaults; accept in_p 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=10, out_ovf=0; in_ready=1 again the cycle after the handshake.
- Max products: 225 x4 -> out_sum=900, out_ovf=0.
- Backpressure: result pending, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum stable at 900 all 3 cycles; out_ready=1 -> out_valid=0 next cycle, no input lost.
- Overflow: N_TERMS=2, ACC_W=8; inputs 200 then 100 -> out_sum=44, out_ovf=1. The next result, 3+4, gives 7 with out_ovf=0.
- Mid-op reset/clear:
  - Accept 9,9, then pulse rst asynchronously (between edges) -> all outputs 0 immediately.
  - Then feed 5,5,5,5 -> out_sum=20.
  - Repeat using clr after 2 terms, with in_valid=1 the same cycle -> that term is dropped; 5,5,5,5 afterwards -> 20.
- Bubbles: in_valid toggled 1,0,0,1,0,1,1 with in_p=7 -> single result 28 after the 4th accepted term; busy=1 from the first accept until the result registers.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Definitions shared by the product accumulator (mac_acc8) and its adder.
//   PROD_W  : width of one incoming product (4x4 unsigned multiplier output)
//   state_t : accumulator FSM states
//   clog2   : ceiling log2, used to size the accumulator and term counter
// -----------------------------------------------------------------------------
package mac_pkg;

   localparam int PROD_W = 8;

   typedef enum logic {
      ACC  = 1'b0,   // collecting terms of a dot product
      HOLD = 1'b1    // result registered, waiting for downstream to take it
   } state_t;

   // clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/acc_add.sv
// -----------------------------------------------------------------------------
// acc_add
// ACC_W-bit unsigned adder: partial sum plus a zero-extended product.
// Ports:
//   i_a     [ACC_W-1:0]  current partial sum
//   i_b     [PROD_W-1:0] incoming product
//   o_sum   [ACC_W-1:0]  sum modulo 2^ACC_W
//   o_carry              carry out of bit ACC_W-1
// -----------------------------------------------------------------------------
module acc_add
   import mac_pkg::*;
#(
   parameter int ACC_W = 10
) (
   input  logic [ACC_W-1:0]  i_a,
   input  logic [PROD_W-1:0] i_b,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_carry
);

   // One bit wider than the accumulator so the top bit is the carry.
   logic [ACC_W:0] w_full;

   assign w_full  = {1'b0, i_a} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_b};
   assign o_sum   = w_full[ACC_W-1:0];
   assign o_carry = w_full[ACC_W];

endmodule

// File: rtl/mac_acc8.sv
// -----------------------------------------------------------------------------
// mac_acc8
// Sums each group of N_TERMS consecutive 8-bit products into one result and
// holds that result on a valid/ready output until it is taken.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. Once out_valid is 1 it stays 1, with out_sum/out_ovf unchanged,
// until out_ready is seen. in_ready is low while a result is held, so there is
// a one-cycle bubble after each output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   clr        synchronous discard of the partial sum (wins over in_valid)
//   in_valid   in_p is valid
//   in_ready   block accepts in_p this cycle
//   in_p       unsigned product
//   out_valid  out_sum/out_ovf are valid
//   out_ready  downstream takes the result
//   out_sum    sum of N_TERMS products modulo 2^ACC_W
//   out_ovf    a carry out of ACC_W occurred while forming this result
//   busy       partial sum in progress (term counter non-zero)
//   dbg_state  current FSM state (0 = ACC, 1 = HOLD)
// -----------------------------------------------------------------------------
module mac_acc8
   import mac_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = PROD_W + clog2(N_TERMS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic              busy,
   output logic              dbg_state
);

   localparam int                CNT_W    = (N_TERMS > 1) ? clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_TERMS - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf_acc;
   logic [ACC_W-1:0]  r_out_sum;
   logic              r_out_ovf;
   logic              r_out_valid;

   logic              w_accept;
   logic              w_last;
   logic [ACC_W-1:0]  w_sum;
   logic              w_carry;

   acc_add #(.ACC_W(ACC_W)) u_acc_add (
      .i_a     (r_acc),
      .i_b     (in_p),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   // in_ready is gated by rst so nothing is offered as accepted while the
   // block is held in reset.
   assign in_ready  = (r_state == ACC) && !rst;
   assign w_accept  = in_valid && in_ready && !clr;
   assign w_last    = (r_cnt == CNT_LAST);

   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_ovf   = r_out_ovf;
   assign busy      = (r_cnt != '0);
   assign dbg_state = r_state;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACC:     if (w_accept && w_last) w_state_next = HOLD;
         HOLD:    if (out_ready)          w_state_next = ACC;
         default: w_state_next = ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf_acc   <= 1'b0;
         r_out_sum   <= '0;
         r_out_ovf   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ACC) begin
            if (clr) begin
               r_acc     <= '0;
               r_cnt     <= '0;
               r_ovf_acc <= 1'b0;
            end else if (w_accept) begin
               if (w_last) begin
                  // Final term goes straight into the output register.
                  r_out_sum   <= w_sum;
                  r_out_ovf   <= r_ovf_acc | w_carry;
                  r_out_valid <= 1'b1;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_ovf_acc   <= 1'b0;
               end else begin
                  r_acc     <= w_sum;
                  r_cnt     <= r_cnt + CNT_W'(1);
                  r_ovf_acc <= r_ovf_acc | w_carry;
               end
            end
         end else if (out_ready) begin
            // HOLD: only the output handshake releases the result; clr and
            // in_valid have no effect here.
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
